// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI transaction sequencer: TX/RX byte FIFOs, slave-select setup/hold,
// one core start per byte. Define SPI_BURST_LSB_FIRST_EN for LSB-first wire order.

module spi_burst_fifo #(
   parameter int AW = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   // full is checked before the pop, so a push into a full FIFO is dropped
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wptr <= AW'(wptr + 1'b1);
         if (do_pop)  rptr <= AW'(rptr + 1'b1);
         if (do_push && !do_pop) begin
            empty <= 1'b0;
            full  <= (AW'(wptr + 1'b1) == rptr);
         end else if (do_pop && !do_push) begin
            full  <= 1'b0;
            empty <= (AW'(rptr + 1'b1) == wptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign rdata = empty ? 8'h00 : mem[rptr];
endmodule

module spi_burst_ctrl #(
   parameter int FIFO_AW = 3,
   parameter int SS_DLY  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_wr,
   input  logic [7:0] tx_wdata,
   output logic       tx_full,
   input  logic       rx_rd,
   output logic [7:0] rx_rdata,
   output logic       rx_empty,
   input  logic       go,
   input  logic [7:0] len,
   output logic       busy,
   output logic       done_tick,
   output logic       ss_n,
   output logic [7:0] spi_din,
   output logic       spi_start,
   input  logic       spi_ready,
   input  logic       spi_done_tick,
   input  logic [7:0] spi_dout
);
   localparam int CW = $clog2(SS_DLY + 1);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, HOLD} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    rem, rem_n;
   logic          ss_n_n, start_n, done_n;
   logic [7:0]    din_n;
   logic          tx_pop, rx_push, tx_empty, rx_full;
   logic [7:0]    tx_head, tx_byte, rx_byte;

`ifdef SPI_BURST_LSB_FIRST_EN
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction
   assign tx_byte = rev8(tx_head);
   assign rx_byte = rev8(spi_dout);
`else
   assign tx_byte = tx_head;
   assign rx_byte = spi_dout;
`endif

   spi_burst_fifo #(.AW(FIFO_AW)) u_tx (
      .clk(clk), .reset(reset), .push(tx_wr), .wdata(tx_wdata), .pop(tx_pop),
      .rdata(tx_head), .full(tx_full), .empty(tx_empty)
   );

   spi_burst_fifo #(.AW(FIFO_AW)) u_rx (
      .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_byte), .pop(rx_rd),
      .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         ss_n      <= 1'b1;
         spi_din   <= '0;
         spi_start <= 1'b0;
         done_tick <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rem       <= rem_n;
         ss_n      <= ss_n_n;
         spi_din   <= din_n;
         spi_start <= start_n;
         done_tick <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rem_n   = rem;
      ss_n_n  = ss_n;
      din_n   = spi_din;
      start_n = 1'b0;
      done_n  = 1'b0;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
      unique case (state)
         IDLE: begin
            if (go && len != 8'd0) begin
               rem_n   = len;
               cnt_n   = '0;
               ss_n_n  = 1'b0;
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (cnt == CW'(SS_DLY - 1)) begin
               cnt_n   = '0;
               state_n = LOAD;
            end else begin
               cnt_n = CW'(cnt + 1'b1);
            end
         end
         LOAD: begin
            // a byte only starts with an RX slot free, so the RX push never overflows
            if (spi_ready && !tx_empty && !rx_full) begin
               din_n   = tx_byte;
               start_n = 1'b1;
               tx_pop  = 1'b1;
               state_n = XFER;
            end
         end
         XFER: begin
            if (spi_done_tick) begin
               rx_push = 1'b1;
               rem_n   = rem - 8'd1;
               state_n = (rem == 8'd1) ? HOLD : LOAD;
            end
         end
         HOLD: begin
            if (cnt == CW'(SS_DLY - 1)) begin
               cnt_n   = '0;
               ss_n_n  = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = CW'(cnt + 1'b1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: loopback core model, queue-based reference
// of TX/RX byte flow, directed scenarios with random data and random core latency.

module tb_spi_burst_ctrl;
   localparam int SS_DLY  = 4;
   localparam int FIFO_AW = 3;
   localparam int DEPTH   = 1 << FIFO_AW;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_wr;
   logic [7:0] tx_wdata;
   logic       tx_full;
   logic       rx_rd;
   logic [7:0] rx_rdata;
   logic       rx_empty;
   logic       go;
   logic [7:0] len;
   logic       busy, done_tick, ss_n;
   logic [7:0] spi_din;
   logic       spi_start, spi_ready, spi_done_tick;
   logic [7:0] spi_dout;

   spi_burst_ctrl #(.FIFO_AW(FIFO_AW), .SS_DLY(SS_DLY)) dut (
      .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .go(go), .len(len),
      .busy(busy), .done_tick(done_tick), .ss_n(ss_n), .spi_din(spi_din),
      .spi_start(spi_start), .spi_ready(spi_ready), .spi_done_tick(spi_done_tick),
      .spi_dout(spi_dout)
   );

   always #5 clk = ~clk;

   // byte core model: takes a start when idle, loops the shifted byte back after a random delay
   logic       core_busy;
   logic [7:0] cap;
   int         ctr;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         core_busy     <= 1'b0;
         spi_done_tick <= 1'b0;
         spi_dout      <= 8'h00;
         cap           <= 8'h00;
         ctr           <= 0;
      end else begin
         spi_done_tick <= 1'b0;
         if (core_busy) begin
            if (ctr == 0) begin
               core_busy     <= 1'b0;
               spi_done_tick <= 1'b1;
               spi_dout      <= cap;
            end else begin
               ctr <= ctr - 1;
            end
         end else if (spi_start) begin
            core_busy <= 1'b1;
            cap       <= spi_din;
            ctr       <= int'($urandom_range(0, 5));
         end
      end
   end
   assign spi_ready = !core_busy;

   // observation: cycle count, start log, done pulses
   int         cyc = 0;
   int         dones = 0;
   int         done_cyc = 0;
   int         sdt_cyc = 0;
   logic [7:0] got_starts [$];
   int         got_start_cyc [$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (spi_start) begin
         got_starts.push_back(spi_din);
         got_start_cyc.push_back(cyc);
      end
      if (done_tick) begin
         dones    <= dones + 1;
         done_cyc <= cyc;
      end
      if (spi_done_tick) sdt_cyc <= cyc;
   end

   // reference model: host-visible byte queues
   logic [7:0] tx_model [$];
   logic [7:0] rx_model [$];
   int passed = 0;
   int total  = 0;

   function automatic logic [7:0] wire_byte(input logic [7:0] b);
      logic [7:0] r;
      r = b;
`ifdef SPI_BURST_LSB_FIRST_EN
      r = 8'h00;
      for (int i = 0; i < 8; i++) if (b[i]) r = r + 8'(1 << (7 - i));
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      if (tx_model.size() < DEPTH) tx_model.push_back(b);
      tx_wr = 1'b1; tx_wdata = b;
      tick(1);
      tx_wr = 1'b0;
   endtask

   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++) push_tx(8'($urandom));
   endtask

   task automatic pulse_go(input logic [7:0] l);
      go = 1'b1; len = l;
      tick(1);
      go = 1'b0;
   endtask

   task automatic pop_rx(input string tag);
      logic [7:0] e;
      e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
      chk(tag, rx_rdata, e);
      rx_rd = 1'b1;
      tick(1);
      rx_rd = 1'b0;
   endtask

   task automatic drain_rx(input string tag);
      while (rx_model.size() != 0) pop_rx(tag);
      chk({tag, "_rx_empty"}, rx_empty, 1'b1);
   endtask

   task automatic wait_done(input int d0, input string tag);
      for (int i = 0; i < 3000 && dones <= d0; i++) tick(1);
      chk({tag, "_done_seen"}, dones > d0, 1'b1);
   endtask

   // compare logged starts against the model and move the bytes into the RX model
   task automatic check_starts(input int n, input string tag);
      logic [7:0] b;
      chk({tag, "_start_count"}, got_starts.size(), n);
      for (int i = 0; i < n; i++) begin
         b = (tx_model.size() != 0) ? tx_model.pop_front() : 8'h00;
         if (i < got_starts.size()) chk({tag, "_spi_din"}, got_starts[i], wire_byte(b));
         rx_model.push_back(b);
      end
   endtask

   task automatic run_burst(input int n, input string tag);
      int d0, c;
      d0 = dones;
      got_starts.delete();
      got_start_cyc.delete();
      c = cyc;
      pulse_go(8'(n));
      chk({tag, "_busy_rise"}, busy, 1'b1);
      wait_done(d0, tag);
      tick(2);
      chk({tag, "_done_once"}, dones - d0, 1);
      if (got_start_cyc.size() != 0)
         chk({tag, "_first_start_cyc"}, got_start_cyc[0] - c, SS_DLY + 2);
      chk({tag, "_hold_cyc"}, done_cyc - sdt_cyc, SS_DLY + 1);
      chk({tag, "_idle"}, {busy, ss_n}, 2'b01);
      check_starts(n, tag);
   endtask

   initial begin
      int d0, n, k;
      logic [7:0] b;
      reset = 1'b1; go = 1'b0; len = 8'h00; tx_wr = 1'b0; tx_wdata = 8'h00; rx_rd = 1'b0;
      tick(3);
      chk("rst_ss_n", ss_n, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_full", tx_full, 1'b0);
      chk("rst_rx_empty", rx_empty, 1'b1);
      chk("rst_rx_rdata", rx_rdata, 8'h00);
      chk("rst_start_din_done", {spi_start, spi_din, done_tick}, 10'h000);
      reset = 1'b0;
      tick(2);

      push_tx(8'hA5); push_tx(8'h3C);
      run_burst(2, "basic");
      drain_rx("basic");

      push_tx(8'h01);
      run_burst(1, "order");
      drain_rx("order");

      for (int r = 0; r < 3; r++) begin
         n = int'($urandom_range(1, 7));
         push_rand(n);
         run_burst(n, "rand");
         drain_rx("rand");
      end

      // TX underrun stalls with ss_n low
      push_rand(1);
      d0 = dones; got_starts.delete();
      pulse_go(8'd3);
      tick(50);
      chk("underrun_stall", {busy, ss_n}, 2'b10);
      chk("underrun_starts", got_starts.size(), 1);
      push_rand(2);
      wait_done(d0, "underrun");
      check_starts(3, "underrun");
      drain_rx("underrun");

      // RX full holds off the start until the host pops
      push_rand(DEPTH);
      run_burst(DEPTH, "fill");
      chk("fill_rx_nonempty", rx_empty, 1'b0);
      push_rand(1);
      d0 = dones; got_starts.delete();
      pulse_go(8'd1);
      tick(30);
      chk("rxfull_no_start", got_starts.size(), 0);
      chk("rxfull_busy", busy, 1'b1);
      pop_rx("rxfull_pop");
      wait_done(d0, "rxfull");
      check_starts(1, "rxfull");

      // pop in the same cycle as the core's done: count must stay put
      push_rand(1);
      d0 = dones; got_starts.delete();
      pulse_go(8'd1);
      tick(10);
      pop_rx("simul_pop1");
      k = 0;
      while (k < 200 && !spi_done_tick) begin
         @(negedge clk);
         k++;
      end
      chk("simul_sdt_seen", spi_done_tick, 1'b1);
      chk("simul_head", rx_rdata, rx_model[0]);
      rx_rd = 1'b1;
      @(posedge clk); #1;
      rx_rd = 1'b0;
      b = rx_model.pop_front();
      wait_done(d0, "simul");
      check_starts(1, "simul");
      drain_rx("simul");

      // asynchronous reset during the second byte
      push_rand(DEPTH);
      chk("pre_rst_tx_full", tx_full, 1'b1);
      got_starts.delete();
      go = 1'b1; len = 8'd3;
      tick(1);
      go = 1'b0;
      k = 0;
      while (k < 400 && got_starts.size() < 2) begin
         @(negedge clk);
         k++;
      end
      chk("mid_second_start", got_starts.size() >= 2, 1'b1);
      chk("mid_rx_nonempty", rx_empty, 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_ss_n", ss_n, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_tx_full", tx_full, 1'b0);
      chk("mid_rst_rx_empty", rx_empty, 1'b1);
      chk("mid_rst_start", spi_start, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      tx_model.delete(); rx_model.delete();
      tick(2);
      push_rand(2);
      run_burst(2, "post_rst");
      drain_rx("post_rst");

      // len=0 and go while busy are no-ops
      pulse_go(8'd0);
      tick(5);
      chk("len0_busy", {busy, ss_n}, 2'b01);
      push_rand(1);
      d0 = dones; got_starts.delete();
      pulse_go(8'd1);
      tick(1);
      pulse_go(8'd5);
      wait_done(d0, "go_busy");
      tick(10);
      chk("go_busy_idle", busy, 1'b0);
      chk("go_busy_dones", dones - d0, 1);
      check_starts(1, "go_busy");
      drain_rx("go_busy");

      // 9th write into a full TX FIFO is dropped
      push_rand(DEPTH + 1);
      chk("full_flag", tx_full, 1'b1);
      run_burst(DEPTH, "full");
      drain_rx("full");
      chk("full_after", tx_full, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
